mc_control: RTL and testbench

- Multicycle main control FSM for the MIPS datapath.
- Sequences fetch, decode, execute, memory and writeback over several clocks, and drives every datapath enable and mux select.
- Drives the 3-bit ALUOp consumed by ALU_control. Samples that unit's Jr output to redirect the PC.
- Stalls on a single-port memory via a mem_ready handshake.

---
 rtl/mips_defs.sv | 73 +++++++
 rtl/mc_control_out.sv | 86 ++++++++
 rtl/mc_control.sv | 105 ++++++++++
 tb/tb_mc_control.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mips_defs.sv
// Shared MIPS control encodings: opcodes, ALUOp, mux selects, FSM states.
package mips_defs;

  typedef logic [5:0] opcode_t;
  typedef logic [3:0] state_t;

  localparam opcode_t OP_RTYPE = 6'b000000;
  localparam opcode_t OP_LW    = 6'b100011;
  localparam opcode_t OP_SW    = 6'b101011;
  localparam opcode_t OP_BEQ   = 6'b000100;
  localparam opcode_t OP_ADDI  = 6'b001000;
  localparam opcode_t OP_ANDI  = 6'b001100;
  localparam opcode_t OP_ORI   = 6'b001101;
  localparam opcode_t OP_J     = 6'b000010;

  localparam logic [2:0] ALUOP_ADD = 3'b000;
  localparam logic [2:0] ALUOP_SUB = 3'b001;
  localparam logic [2:0] ALUOP_R   = 3'b010;
  localparam logic [2:0] ALUOP_AND = 3'b100;
  localparam logic [2:0] ALUOP_OR  = 3'b101;

  localparam logic [1:0] ASB_RT   = 2'b00;
  localparam logic [1:0] ASB_FOUR = 2'b01;
  localparam logic [1:0] ASB_IMM  = 2'b10;
  localparam logic [1:0] ASB_BOFS = 2'b11;

  localparam logic [1:0] PCS_ALU  = 2'b00;
  localparam logic [1:0] PCS_OUT  = 2'b01;
  localparam logic [1:0] PCS_JMP  = 2'b10;
  localparam logic [1:0] PCS_RS   = 2'b11;

  localparam state_t S_IDLE   = 4'd0;
  localparam state_t S_FETCH  = 4'd1;
  localparam state_t S_DECODE = 4'd2;
  localparam state_t S_MEMADR = 4'd3;
  localparam state_t S_MEMRD  = 4'd4;
  localparam state_t S_MEMWB  = 4'd5;
  localparam state_t S_MEMWR  = 4'd6;
  localparam state_t S_EXEC   = 4'd7;
  localparam state_t S_RWB    = 4'd8;
  localparam state_t S_BRANCH = 4'd9;
  localparam state_t S_ANDIEX = 4'd10;
  localparam state_t S_ORIEX  = 4'd11;
  localparam state_t S_IMMWB  = 4'd12;
  localparam state_t S_JUMP   = 4'd13;
  localparam state_t S_JR     = 4'd14;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic op_legal(input opcode_t op);
    unique case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ,
      OP_ADDI, OP_ANDI, OP_ORI, OP_J: op_legal = 1'b1;
      default:                        op_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_control_out.sv
// Combinational control decode from FSM state; shared with the pipelined core.
module mc_control_out
  import mips_defs::*;
(
  input  state_t  state,
  input  opcode_t opcode,
  input  logic    mem_ready,
  output ctrl_t   ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = ASB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        // IR and PC only load once memory delivers the word
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
        ctrl.pc_source = PCS_ALU;
      end
      S_DECODE: begin
        ctrl.alu_src_b  = ASB_BOFS;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.illegal_op = ~op_legal(opcode);
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ASB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ASB_RT;
        ctrl.alu_op    = ALUOP_R;
      end
      S_RWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = ASB_RT;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCS_OUT;
      end
      S_ANDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ASB_IMM;
        ctrl.alu_op    = ALUOP_AND;
      end
      S_ORIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ASB_IMM;
        ctrl.alu_op    = ALUOP_OR;
      end
      S_IMMWB: begin
        ctrl.reg_write = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCS_JMP;
      end
      S_JR: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCS_RS;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS main control FSM: state register and next-state logic.
module mc_control
  import mips_defs::*;
#(
  parameter int OP_W = 6,
  parameter int ST_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] opcode,
  input  logic            jr,
  input  logic            mem_ready,
  output logic            pc_write,
  output logic            pc_write_cond,
  output logic            iord,
  output logic            mem_read,
  output logic            mem_write,
  output logic            ir_write,
  output logic            mem_to_reg,
  output logic            reg_write,
  output logic            reg_dst,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [2:0]      alu_op,
  output logic [1:0]      pc_source,
  output logic            illegal_op,
  output logic [ST_W-1:0] state
);

  logic [ST_W-1:0] nxt;
  ctrl_t           ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:   nxt = S_FETCH;
      S_FETCH:  nxt = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        // jr is an R-type funct, so it must win over the EXEC path
        if (jr && opcode == OP_RTYPE) nxt = S_JR;
        else begin
          unique case (1'b1)
            (opcode == OP_RTYPE): nxt = S_EXEC;
            (opcode == OP_LW),
            (opcode == OP_SW),
            (opcode == OP_ADDI):  nxt = S_MEMADR;
            (opcode == OP_BEQ):   nxt = S_BRANCH;
            (opcode == OP_ANDI):  nxt = S_ANDIEX;
            (opcode == OP_ORI):   nxt = S_ORIEX;
            (opcode == OP_J):     nxt = S_JUMP;
            default:              nxt = S_FETCH;
          endcase
        end
      end
      S_MEMADR: begin
        unique case (1'b1)
          (opcode == OP_LW):   nxt = S_MEMRD;
          (opcode == OP_SW):   nxt = S_MEMWR;
          (opcode == OP_ADDI): nxt = S_IMMWB;
          default:             nxt = S_FETCH;
        endcase
      end
      S_MEMRD:  nxt = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  nxt = S_FETCH;
      S_MEMWR:  nxt = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   nxt = S_RWB;
      S_RWB:    nxt = S_FETCH;
      S_BRANCH: nxt = S_FETCH;
      S_ANDIEX: nxt = S_IMMWB;
      S_ORIEX:  nxt = S_IMMWB;
      S_IMMWB:  nxt = S_FETCH;
      S_JUMP:   nxt = S_FETCH;
      S_JR:     nxt = S_FETCH;
      default:  nxt = S_FETCH;
    endcase
  end

  mc_control_out u_out (
    .state     (state),
    .opcode    (opcode),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign iord          = ctrl.iord;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_write     = ctrl.reg_write;
  assign reg_dst       = ctrl.reg_dst;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign pc_source     = ctrl.pc_source;
  assign illegal_op    = ctrl.illegal_op;

endmodule

// File: tb/tb_mc_control.sv
// Directed scoreboard bench for mc_control: per-cycle expected state/outputs.
module tb_mc_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       jr;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write;
  logic       ir_write, mem_to_reg, reg_write, reg_dst, alu_src_a;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_op;
  logic       illegal_op;
  logic [3:0] state;

  always #5 clk = ~clk;

  mc_control dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .jr            (jr),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .iord          (iord),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .reg_dst       (reg_dst),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .illegal_op    (illegal_op),
    .state         (state)
  );

  // {pcw,pcwc,iord,mrd,mwr,irw,m2r,rw,rdst,asa,asb[2],aop[3],psrc[2],ill}
  localparam logic [17:0] O_ZERO   = 18'b0;
  localparam logic [17:0] O_FETCH1 = 18'b1_0_0_1_0_1_0_0_0_0_01_000_00_0;
  localparam logic [17:0] O_FETCH0 = 18'b0_0_0_1_0_0_0_0_0_0_01_000_00_0;
  localparam logic [17:0] O_DEC    = 18'b0_0_0_0_0_0_0_0_0_0_11_000_00_0;
  localparam logic [17:0] O_DECILL = 18'b0_0_0_0_0_0_0_0_0_0_11_000_00_1;
  localparam logic [17:0] O_MEMADR = 18'b0_0_0_0_0_0_0_0_0_1_10_000_00_0;
  localparam logic [17:0] O_MEMRD  = 18'b0_0_1_1_0_0_0_0_0_0_00_000_00_0;
  localparam logic [17:0] O_MEMWB  = 18'b0_0_0_0_0_0_1_1_0_0_00_000_00_0;
  localparam logic [17:0] O_MEMWR  = 18'b0_0_1_0_1_0_0_0_0_0_00_000_00_0;
  localparam logic [17:0] O_EXEC   = 18'b0_0_0_0_0_0_0_0_0_1_00_010_00_0;
  localparam logic [17:0] O_RWB    = 18'b0_0_0_0_0_0_0_1_1_0_00_000_00_0;
  localparam logic [17:0] O_BRANCH = 18'b0_1_0_0_0_0_0_0_0_1_00_001_01_0;
  localparam logic [17:0] O_ANDIEX = 18'b0_0_0_0_0_0_0_0_0_1_10_100_00_0;
  localparam logic [17:0] O_ORIEX  = 18'b0_0_0_0_0_0_0_0_0_1_10_101_00_0;
  localparam logic [17:0] O_IMMWB  = 18'b0_0_0_0_0_0_0_1_0_0_00_000_00_0;
  localparam logic [17:0] O_JUMP   = 18'b1_0_0_0_0_0_0_0_0_0_00_000_10_0;
  localparam logic [17:0] O_JR     = 18'b1_0_0_0_0_0_0_0_0_0_00_000_11_0;

  typedef struct {
    int          id;
    logic [3:0]  st;
    logic [17:0] out;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec    = 0;
  bit   done   = 1'b0;

  wire [17:0] act = {pc_write, pc_write_cond, iord, mem_read, mem_write,
                     ir_write, mem_to_reg, reg_write, reg_dst, alu_src_a,
                     alu_src_b, alu_op, pc_source, illegal_op};

  // monitor: compares whatever the stimulus queued for this cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (state !== e.st || act !== e.out) begin
        errors++;
        $display("FAIL vec%0d: state=%0d out=%b required state=%0d out=%b",
                 e.id, state, act, e.st, e.out);
      end
    end
  end

  task automatic step(input logic [5:0] op, input logic j, input logic mr,
                      input logic rst, input logic [3:0] st,
                      input logic [17:0] out);
    exp_t e;
    rst_n     = rst;
    opcode    = op;
    jr        = j;
    mem_ready = mr;
    e.id = vec;
    e.st = st;
    e.out = out;
    vec++;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; opcode = 6'd0; jr = 1'b0; mem_ready = 1'b1;
    @(posedge clk);
    #1;
    step(6'h00, 0, 1, 0, 4'd0,  O_ZERO);
    step(6'h00, 0, 1, 1, 4'd0,  O_ZERO);
    // lw, opcode perturbed in MEMRD must be ignored
    step(6'h23, 0, 1, 1, 4'd1,  O_FETCH1);
    step(6'h23, 0, 1, 1, 4'd2,  O_DEC);
    step(6'h23, 0, 1, 1, 4'd3,  O_MEMADR);
    step(6'h3f, 0, 1, 1, 4'd4,  O_MEMRD);
    step(6'h3f, 0, 1, 1, 4'd5,  O_MEMWB);
    // sw with 3 wait cycles
    step(6'h2b, 0, 1, 1, 4'd1,  O_FETCH1);
    step(6'h2b, 0, 1, 1, 4'd2,  O_DEC);
    step(6'h2b, 0, 1, 1, 4'd3,  O_MEMADR);
    step(6'h2b, 0, 0, 1, 4'd6,  O_MEMWR);
    step(6'h2b, 0, 0, 1, 4'd6,  O_MEMWR);
    step(6'h2b, 0, 0, 1, 4'd6,  O_MEMWR);
    step(6'h2b, 0, 1, 1, 4'd6,  O_MEMWR);
    // jr
    step(6'h00, 1, 1, 1, 4'd1,  O_FETCH1);
    step(6'h00, 1, 1, 1, 4'd2,  O_DEC);
    step(6'h00, 0, 1, 1, 4'd14, O_JR);
    // R-type
    step(6'h00, 0, 1, 1, 4'd1,  O_FETCH1);
    step(6'h00, 0, 1, 1, 4'd2,  O_DEC);
    step(6'h00, 0, 1, 1, 4'd7,  O_EXEC);
    step(6'h00, 0, 1, 1, 4'd8,  O_RWB);
    // ori
    step(6'h0d, 0, 1, 1, 4'd1,  O_FETCH1);
    step(6'h0d, 0, 1, 1, 4'd2,  O_DEC);
    step(6'h0d, 0, 1, 1, 4'd11, O_ORIEX);
    step(6'h0d, 0, 1, 1, 4'd12, O_IMMWB);
    // andi, with a fetch stall
    step(6'h0c, 0, 0, 1, 4'd1,  O_FETCH0);
    step(6'h0c, 0, 1, 1, 4'd1,  O_FETCH1);
    step(6'h0c, 0, 1, 1, 4'd2,  O_DEC);
    step(6'h0c, 0, 1, 1, 4'd10, O_ANDIEX);
    step(6'h0c, 0, 1, 1, 4'd12, O_IMMWB);
    // addi
    step(6'h08, 0, 1, 1, 4'd1,  O_FETCH1);
    step(6'h08, 0, 1, 1, 4'd2,  O_DEC);
    step(6'h08, 0, 1, 1, 4'd3,  O_MEMADR);
    step(6'h08, 0, 1, 1, 4'd12, O_IMMWB);
    // beq
    step(6'h04, 0, 1, 1, 4'd1,  O_FETCH1);
    step(6'h04, 0, 1, 1, 4'd2,  O_DEC);
    step(6'h04, 0, 1, 1, 4'd9,  O_BRANCH);
    // j
    step(6'h02, 0, 1, 1, 4'd1,  O_FETCH1);
    step(6'h02, 0, 1, 1, 4'd2,  O_DEC);
    step(6'h02, 0, 1, 1, 4'd13, O_JUMP);
    // illegal opcode
    step(6'h3f, 0, 1, 1, 4'd1,  O_FETCH1);
    step(6'h3f, 0, 1, 1, 4'd2,  O_DECILL);
    step(6'h3f, 0, 1, 1, 4'd1,  O_FETCH1);
    step(6'h2b, 0, 1, 1, 4'd2,  O_DEC);
    // reset asserted while sw waits in MEMWR
    step(6'h2b, 0, 1, 1, 4'd3,  O_MEMADR);
    step(6'h2b, 0, 0, 1, 4'd6,  O_MEMWR);
    step(6'h2b, 0, 1, 0, 4'd0,  O_ZERO);
    step(6'h2b, 0, 1, 1, 4'd0,  O_ZERO);
    step(6'h2b, 0, 1, 1, 4'd1,  O_FETCH1);
    @(negedge clk);
    #1;
    done = 1'b1;
  end

  initial begin
    fork
      wait (done);
      begin
        #20000;
        errors++;
        $display("FAIL timeout: done=0 required done=1");
      end
    join_any
    disable fork;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
